// File: rtl/clockworks_gen.sv
// Clock/reset infrastructure: reset-stretch sequencer, programmable tick divider and tick counter.
// Optional single-step tick mode is compiled in with CW_STEP_EN.
module clockworks_gen #(
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned DIV_DEFAULT = 0,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             resetn,
    output logic             tick,
    output logic             slow_toggle,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {StHold, StStretch, StRun} state_e;

    state_e            state_q;
    logic [15:0]       rst_cnt_q;
    logic [DIV_W-1:0]  div_reg_q;
    logic [DIV_W-1:0]  div_cnt_q;

    // resetn is set on the same edge that enters RUN so it rises on edge RST_CYCLES+1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StHold;
            rst_cnt_q <= '0;
            resetn    <= 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    state_q   <= StStretch;
                    rst_cnt_q <= '0;
                    resetn    <= 1'b0;
                end
                StStretch: begin
                    if (rst_cnt_q == 16'(RST_CYCLES - 1)) begin
                        state_q <= StRun;
                        resetn  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 16'd1;
                        resetn    <= 1'b0;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                    resetn  <= 1'b1;
                end
                default: begin
                    state_q <= StHold;
                    resetn  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CW_STEP_EN
    logic step_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_req;
        end
    end
`else
    logic unused_step;
    assign unused_step = step_mode ^ step_req;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_reg_q   <= DIV_W'(DIV_DEFAULT);
            div_cnt_q   <= DIV_W'(DIV_DEFAULT);
            tick        <= 1'b0;
            slow_toggle <= 1'b0;
            tick_count  <= '0;
        end else if (div_load) begin
            // Loading restarts the phase: next tick comes div_value+1 cycles later.
            div_reg_q <= div_value;
            div_cnt_q <= div_value;
            tick      <= 1'b0;
        end else if (state_q != StRun) begin
            div_cnt_q <= div_reg_q;
            tick      <= 1'b0;
`ifdef CW_STEP_EN
        end else if (step_mode) begin
            div_cnt_q <= div_reg_q;
            if (step_req && !step_q) begin
                tick        <= 1'b1;
                slow_toggle <= ~slow_toggle;
                tick_count  <= tick_count + CNT_W'(1);
            end else begin
                tick <= 1'b0;
            end
`endif
        end else if (div_cnt_q == '0) begin
            div_cnt_q   <= div_reg_q;
            tick        <= 1'b1;
            slow_toggle <= ~slow_toggle;
            tick_count  <= tick_count + CNT_W'(1);
        end else begin
            div_cnt_q <= div_cnt_q - DIV_W'(1);
            tick      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clockworks_gen.sv
// Directed self-checking bench for clockworks_gen (RST_CYCLES=4, DIV_DEFAULT=0).
module tb_clockworks_gen;

    localparam int unsigned DIV_W = 24;
    localparam int unsigned CNT_W = 32;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             step_mode;
    logic             step_req;
    logic             resetn;
    logic             tick;
    logic             slow_toggle;
    logic [CNT_W-1:0] tick_count;

    int errors = 0;
    int checks = 0;

    clockworks_gen #(
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(0),
        .RST_CYCLES (4),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .div_load   (div_load),
        .div_value  (div_value),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .resetn     (resetn),
        .tick       (tick),
        .slow_toggle(slow_toggle),
        .tick_count (tick_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic clk_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if (resetn !== 1'b0) begin
            errors++; $display("FAIL reset_resetn: got %b want 0", resetn);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b want 0", tick);
        end
        checks++;
        if (slow_toggle !== 1'b0) begin
            errors++; $display("FAIL reset_toggle: got %b want 0", slow_toggle);
        end
        checks++;
        if (tick_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", tick_count);
        end
        RESET = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            clk_step();
            checks++;
            if (resetn !== (e >= 5)) begin
                errors++; $display("FAIL stretch_resetn edge %0d: got %b want %b", e, resetn, e >= 5);
            end
            checks++;
            if (tick !== 1'b0) begin
                errors++; $display("FAIL stretch_tick edge %0d: got %b want 0", e, tick);
            end
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 10; i++) begin
            clk_step();
            checks++;
            if (tick !== 1'b1) begin
                errors++; $display("FAIL free_tick cycle %0d: got %b want 1", i, tick);
            end
            checks++;
            if (tick_count !== 32'(i)) begin
                errors++; $display("FAIL free_count cycle %0d: got %0d want %0d", i, tick_count, i);
            end
            checks++;
            if (slow_toggle !== ((i % 2) == 1)) begin
                errors++; $display("FAIL free_toggle cycle %0d: got %b want %b", i, slow_toggle,
                                   (i % 2) == 1);
            end
        end
    endtask

    task automatic test_div_load();
        div_load  = 1'b1;
        div_value = 24'd3;
        clk_step();
        div_load = 1'b0;
        checks++;
        if (tick !== 1'b0 || tick_count !== 32'd10) begin
            errors++; $display("FAIL load_cycle: got tick=%b count=%0d want tick=0 count=10",
                               tick, tick_count);
        end
        for (int i = 1; i <= 12; i++) begin
            clk_step();
            checks++;
            if (tick !== ((i % 4) == 0)) begin
                errors++; $display("FAIL div3_tick cycle %0d: got %b want %b", i, tick, (i % 4) == 0);
            end
            checks++;
            if (tick_count !== 32'(10 + i / 4)) begin
                errors++; $display("FAIL div3_count cycle %0d: got %0d want %0d", i, tick_count,
                                   10 + i / 4);
            end
            checks++;
            if (slow_toggle !== (((i / 4) % 2) == 1)) begin
                errors++; $display("FAIL div3_toggle cycle %0d: got %b want %b", i, slow_toggle,
                                   ((i / 4) % 2) == 1);
            end
        end
    endtask

    task automatic test_reset_restart();
        // RESET in RUN with div 3 loaded
        RESET = 1'b1;
        clk_step();
        checks++;
        if (resetn !== 1'b0 || tick_count !== 32'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL run_reset: got resetn=%b count=%0d tick=%b want 0/0/0",
                               resetn, tick_count, tick);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) clk_step();
        // Abort mid-stretch (rst_cnt=2)
        RESET = 1'b1;
        clk_step();
        RESET = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            clk_step();
            checks++;
            if (resetn !== (e >= 5)) begin
                errors++; $display("FAIL restretch_resetn edge %0d: got %b want %b", e, resetn, e >= 5);
            end
        end
        clk_step();
        checks++;
        if (tick !== 1'b1 || tick_count !== 32'd1) begin
            errors++; $display("FAIL restretch_div: got tick=%b count=%0d want 1/1", tick, tick_count);
        end
    endtask

    task automatic test_reset_vs_load();
        RESET     = 1'b1;
        div_load  = 1'b1;
        div_value = 24'd7;
        clk_step();
        RESET    = 1'b0;
        div_load = 1'b0;
        for (int e = 1; e <= 5; e++) clk_step();
        checks++;
        if (resetn !== 1'b1) begin
            errors++; $display("FAIL rvl_resetn: got %b want 1", resetn);
        end
        for (int i = 1; i <= 3; i++) begin
            clk_step();
            checks++;
            if (tick !== 1'b1 || tick_count !== 32'(i)) begin
                errors++; $display("FAIL rvl_period cycle %0d: got tick=%b count=%0d want 1/%0d",
                                   i, tick, tick_count, i);
            end
        end
    endtask

`ifdef CW_STEP_EN
    task automatic test_step();
        int unsigned c0;
        int          nticks;
        logic        prev;
        logic        want;
        logic        pat[30];
        for (int i = 0; i < 30; i++) pat[i] = 1'b0;
        for (int i = 0; i < 20; i++) pat[i] = 1'b1;
        pat[22] = 1'b1;
        pat[25] = 1'b1;
        pat[28] = 1'b1;
        div_load  = 1'b1;
        div_value = 24'd5;
        step_mode = 1'b1;
        step_req  = 1'b0;
        clk_step();
        div_load = 1'b0;
        c0       = tick_count;
        prev     = 1'b0;
        nticks   = 0;
        for (int i = 0; i < 30; i++) begin
            step_req = pat[i];
            clk_step();
            want = pat[i] && !prev;
            prev = pat[i];
            if (tick === 1'b1) nticks++;
            checks++;
            if (tick !== want) begin
                errors++; $display("FAIL step_tick cycle %0d: got %b want %b", i, tick, want);
            end
        end
        checks++;
        if (nticks != 4 || tick_count !== 32'(c0 + 4)) begin
            errors++; $display("FAIL step_total: got ticks=%0d count=%0d want 4/%0d",
                               nticks, tick_count, c0 + 4);
        end
        step_mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            clk_step();
            checks++;
            if (tick !== (i == 6)) begin
                errors++; $display("FAIL step_exit cycle %0d: got %b want %b", i, tick, i == 6);
            end
        end
    endtask
`else
    task automatic test_step_ignored();
        int unsigned c0;
        c0        = tick_count;
        step_mode = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step_req = (i % 2) == 1;
            clk_step();
            checks++;
            if (tick !== 1'b1 || tick_count !== 32'(c0 + i)) begin
                errors++; $display("FAIL step_ignored cycle %0d: got tick=%b count=%0d want 1/%0d",
                                   i, tick, tick_count, c0 + i);
            end
        end
        step_mode = 1'b0;
        step_req  = 1'b0;
    endtask
`endif

    initial begin
        RESET     = 1'b1;
        div_load  = 1'b0;
        div_value = '0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        test_reset();
        test_free_run();
        test_div_load();
        test_reset_restart();
        // Load div 3 in RUN, then reset again: div must return to default
        div_load  = 1'b1;
        div_value = 24'd3;
        clk_step();
        div_load = 1'b0;
        for (int i = 0; i < 4; i++) clk_step();
        test_reset_restart();
        test_reset_vs_load();
`ifdef CW_STEP_EN
        test_step();
`else
        test_step_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clockworks_gen.md
Name: clockworks_gen

Overview:
- Parametrised clock/reset infrastructure block for the RV32I core on the Arty board.
- Runs the whole design on the single board clock. Slow operation uses a clock-enable `tick` instead of a derived clock, so there are no divided clock nets.
- Provides:
  - a reset-stretch sequencer producing `resetn`;
  - a runtime-programmable tick divider;
  - an observable toggling slow signal for LEDs;
  - a tick counter for cycle/perf CSRs.

Parameters:
- DIV_W, 24, width of divider value and counter.
- DIV_DEFAULT, 0, divider value after reset (0 = tick every cycle).
- RST_CYCLES, 16, cycles `resetn` stays low after RESET deasserts; legal range 1..65535.
- CNT_W, 32, width of `tick_count`.

Ports:
- CLK  in  1  board clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- div_load  in  1  load `div_value` into the divider register.
- div_value  in  DIV_W  new divider value; tick period is `div_value`+1 cycles.
- step_mode  in  1  single-step mode select (used only with CW_STEP_EN).
- step_req  in  1  step request, level input, edge-detected internally.
- resetn  out  1  active-low design reset, registered.
- tick  out  1  one-cycle clock-enable pulse.
- slow_toggle  out  1  toggles on every tick.
- tick_count  out  CNT_W  number of ticks since `resetn` rose.

Behaviour:
- All state updates on posedge CLK. RESET is sampled synchronously and has priority over every other input.
- Reset values: `resetn`=0, `tick`=0, `slow_toggle`=0, `tick_count`=0, div_reg=DIV_DEFAULT, div_cnt=DIV_DEFAULT, FSM=HOLD, rst_cnt=0, step edge register=0.
- Sequencer FSM:
  - HOLD: RESET sampled low -> STRETCH, rst_cnt<=0.
  - STRETCH: rst_cnt==RST_CYCLES-1 -> RUN; otherwise rst_cnt++.
  - RUN: stays in RUN until RESET.
  - RESET high in any state -> HOLD immediately, including mid-STRETCH and in RUN.
- `resetn` is the registered value of (state==RUN). It rises on the (RST_CYCLES+1)-th edge that samples RESET low. Example: RST_CYCLES=4 gives rise on edge 5.
- Divider (outside RUN):
  - `tick`=0; div_cnt<=div_reg each cycle.
  - `tick_count` and `slow_toggle` are held.
- Divider (in RUN):
  - div_cnt==0: `tick`<=1, div_cnt<=div_reg, `slow_toggle` inverts, `tick_count`++.
  - Otherwise: `tick`<=0, div_cnt--.
  - First tick asserts div_reg+1 cycles after `resetn` rises.
  - Steady period is div_reg+1. With div_reg=0, `tick` is constantly 1.
- `div_load` (not under RESET):
  - div_reg<=div_value and div_cnt<=div_value; `tick`<=0 that cycle, so the phase restarts.
  - Accepted in any FSM state. The value is retained through the sequencer; only RESET restores DIV_DEFAULT.
  - RESET and `div_load` together: RESET wins.
- `tick_count` wraps from 2^CNT_W-1 to 0 silently.
- `tick` is a single registered pulse and is never stretched.

Optional Feature:
- Macro: CW_STEP_EN.
- Defined, `step_mode`=1 in RUN:
  - Free-running ticks are suppressed and div_cnt is held at div_reg.
  - The register step_q tracks `step_req`.
  - A rising edge (step_req=1 with step_q=0) yields exactly one `tick` on the following cycle, with `slow_toggle` and `tick_count` updated.
  - Holding `step_req` high gives no further ticks.
- Defined, `step_mode` 1->0: div_cnt restarts from div_reg, so the first free tick comes div_reg+1 cycles later.
- Not defined: `step_mode` and `step_req` are ignored, with no step_q logic. They remain in the port list for pin compatibility.

Test Plan:
- RST_CYCLES=4, RESET high 3 cycles then low -> `resetn` low through edge 4 after release, high after edge 5. `tick`=0 throughout.
- DIV_DEFAULT=0 after `resetn` rises -> `tick`=1 every cycle; `tick_count` = 10 after 10 cycles; `slow_toggle` alternates each cycle.
- `div_load` with `div_value`=3 in RUN -> `tick` low for 3 cycles, then pulses every 4 cycles; `slow_toggle` period 8 cycles.
- RESET pulsed for 1 cycle mid-STRETCH (rst_cnt=2) and again in RUN with `div_value`=3 loaded -> sequencer restarts, full 4-cycle stretch, div_reg back to 0, `tick_count`=0.
- RESET and `div_load` (`div_value`=7) in the same cycle -> div_reg=DIV_DEFAULT; post-reset tick period is 1.
- CW_STEP_EN, `step_mode`=1, div_reg=5, `step_req` held high 20 cycles then low, then 3 separate pulses -> exactly 4 ticks total, each one cycle wide, one cycle after each rising edge; `tick_count`=4.
